// File: rtl/mac_operand_feeder_if.sv
// mac_operand_feeder_if: configuration, operand-write and MAC-issue signals of mac_operand_feeder.
// MAC_FEEDER_STALL_CNT_EN adds the stall_cnt output.
interface mac_operand_feeder_if #(parameter int DW = 16);
    logic          cfg_req, cfg_float_int, cfg_ack;
    logic [7:0]    cfg_len;
    logic          a_valid, a_ready, b_valid, b_ready;
    logic [DW-1:0] a_data, b_data, mac_a, mac_b;
    logic          config_en, float_int, mac_valid_a, mac_valid_b, busy, vec_done;
    logic [7:0]    data_num;
`ifdef MAC_FEEDER_STALL_CNT_EN
    logic [15:0]   stall_cnt;
    modport slave (
        input  cfg_req, cfg_float_int, cfg_len, a_valid, a_data, b_valid, b_data,
        output cfg_ack, a_ready, b_ready, config_en, float_int, data_num,
               mac_a, mac_b, mac_valid_a, mac_valid_b, busy, vec_done, stall_cnt
    );
    modport master (
        output cfg_req, cfg_float_int, cfg_len, a_valid, a_data, b_valid, b_data,
        input  cfg_ack, a_ready, b_ready, config_en, float_int, data_num,
               mac_a, mac_b, mac_valid_a, mac_valid_b, busy, vec_done, stall_cnt
    );
`else
    modport slave (
        input  cfg_req, cfg_float_int, cfg_len, a_valid, a_data, b_valid, b_data,
        output cfg_ack, a_ready, b_ready, config_en, float_int, data_num,
               mac_a, mac_b, mac_valid_a, mac_valid_b, busy, vec_done
    );
    modport master (
        output cfg_req, cfg_float_int, cfg_len, a_valid, a_data, b_valid, b_data,
        input  cfg_ack, a_ready, b_ready, config_en, float_int, data_num,
               mac_a, mac_b, mac_valid_a, mac_valid_b, busy, vec_done
    );
`endif
endinterface

// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: buffers A/B operand streams and issues time-aligned pairs to the MAC, one config per vector.
// Define MAC_FEEDER_STALL_CNT_EN to add stall_cnt (RUN cycles with exactly one operand FIFO empty).
module mac_operand_feeder #(
    parameter int DW    = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    mac_operand_feeder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CONF, SETTLE, RUN} state_t;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    state_t        state, state_d;
    logic [DW-1:0] a_mem [DEPTH];
    logic [DW-1:0] b_mem [DEPTH];
    logic [AW-1:0] a_wp, a_rp, b_wp, b_rp;
    logic [AW:0]   a_cnt, b_cnt, a_cnt_d, b_cnt_d;
    logic          a_rdy, b_rdy, a_push, b_push, accept, pop, last;
    logic [8:0]    issue_cnt, len_eff;
    logic [7:0]    len_q;
    logic          cfg_ack_q, float_q, valid_q, done_q, busy_q;
    logic [DW-1:0] mac_a_q, mac_b_q;

    assign len_eff = {len_q == 8'd0, len_q};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_d;

    always_comb begin
        accept  = state == IDLE && bus.cfg_req;
        pop     = state == RUN && a_cnt != '0 && b_cnt != '0;
        last    = pop && issue_cnt + 9'd1 == len_eff;
        state_d = accept ? CONF : state == CONF ? SETTLE : state == SETTLE ? RUN : last ? IDLE : state;
    end

    // ready is registered, so full is judged on the occupancy after this edge
    always_comb begin
        a_push  = bus.a_valid && a_rdy;
        b_push  = bus.b_valid && b_rdy;
        a_cnt_d = a_cnt + (AW+1)'(a_push) - (AW+1)'(pop);
        b_cnt_d = b_cnt + (AW+1)'(b_push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (a_push) a_mem[a_wp] <= bus.a_data;
        if (b_push) b_mem[b_wp] <= bus.b_data;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            {a_wp, a_rp, b_wp, b_rp, a_cnt, b_cnt} <= '0;
            {a_rdy, b_rdy, cfg_ack_q, float_q, valid_q, done_q, busy_q} <= '0;
            issue_cnt <= '0;
            len_q     <= '0;
            mac_a_q   <= '0;
            mac_b_q   <= '0;
        end else begin
            a_cnt     <= a_cnt_d;
            b_cnt     <= b_cnt_d;
            a_rdy     <= a_cnt_d != FULL;
            b_rdy     <= b_cnt_d != FULL;
            cfg_ack_q <= accept;
            valid_q   <= pop;
            done_q    <= last;
            busy_q    <= state_d != IDLE;
            if (a_push) a_wp <= a_wp + AW'(1);
            if (b_push) b_wp <= b_wp + AW'(1);
            if (pop) begin
                a_rp      <= a_rp + AW'(1);
                b_rp      <= b_rp + AW'(1);
                mac_a_q   <= a_mem[a_rp];
                mac_b_q   <= b_mem[b_rp];
                issue_cnt <= issue_cnt + 9'd1;
            end
            if (accept) begin
                float_q   <= bus.cfg_float_int;
                len_q     <= bus.cfg_len;
                issue_cnt <= '0;
            end
        end

`ifdef MAC_FEEDER_STALL_CNT_EN
    logic [15:0] stall_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) stall_q <= '0;
        else if (accept || state == CONF) stall_q <= '0;
        else if (state == RUN && (a_cnt == '0) != (b_cnt == '0) && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    assign bus.stall_cnt = stall_q;
`endif

    assign bus.a_ready     = a_rdy;
    assign bus.b_ready     = b_rdy;
    assign bus.cfg_ack     = cfg_ack_q;
    assign bus.config_en   = cfg_ack_q;
    assign bus.float_int   = float_q;
    assign bus.data_num    = len_q;
    assign bus.mac_a       = mac_a_q;
    assign bus.mac_b       = mac_b_q;
    assign bus.mac_valid_a = valid_q;
    assign bus.mac_valid_b = valid_q;
    assign bus.vec_done    = done_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_mac_operand_feeder.sv
// tb_mac_operand_feeder: directed self-checking bench for mac_operand_feeder.
module tb_mac_operand_feeder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    mac_operand_feeder_if #(.DW(16)) bus();
    mac_operand_feeder #(.DW(16), .DEPTH(8), .AW(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
        bus.a_valid = 1'b1;
        bus.a_data  = a;
        bus.b_valid = 1'b1;
        bus.b_data  = b;
        tick();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.cfg_req = 0; bus.cfg_float_int = 0; bus.cfg_len = 0;
        bus.a_valid = 0; bus.a_data = 0; bus.b_valid = 0; bus.b_data = 0;
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({bus.cfg_ack, bus.config_en, bus.float_int, bus.data_num, bus.mac_a, bus.mac_b, bus.mac_valid_a,
             bus.mac_valid_b, bus.busy, bus.vec_done, bus.a_ready, bus.b_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got nonzero outputs ack=%b ready=%b%b busy=%b", bus.cfg_ack, bus.a_ready, bus.b_ready, bus.busy);
        end
        tick();
        #2 rst_n = 1'b1;
        n_checks++;
        if (bus.a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_early: got %b expected 0", bus.a_ready); end
        tick();
        n_checks++;
        if ({bus.a_ready, bus.b_ready} !== 2'b11) begin n_fail++; $display("FAIL reset_ready: got %b expected 11", {bus.a_ready, bus.b_ready}); end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) push_pair(16'h0010 + 16'(i), 16'h0020 + 16'(i));
        bus.cfg_req = 1; bus.cfg_len = 8'd4; bus.cfg_float_int = 0;
        tick();
        bus.cfg_req = 0;
        n_checks++;
        if ({bus.cfg_ack, bus.config_en, bus.busy} !== 3'b111) begin n_fail++; $display("FAIL basic_ack: got %b expected 111", {bus.cfg_ack, bus.config_en, bus.busy}); end
        n_checks++;
        if ({bus.float_int, bus.data_num} !== 9'd4) begin n_fail++; $display("FAIL basic_cfg: got %h expected 004", {bus.float_int, bus.data_num}); end
        tick();
        n_checks++;
        if ({bus.cfg_ack, bus.config_en, bus.mac_valid_a} !== 3'b000) begin n_fail++; $display("FAIL basic_pulse: got %b expected 000", {bus.cfg_ack, bus.config_en, bus.mac_valid_a}); end
        tick();
        n_checks++;
        if (bus.mac_valid_a !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b expected 0", bus.mac_valid_a); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if ({bus.mac_valid_a, bus.mac_valid_b, bus.vec_done, bus.mac_a, bus.mac_b} !==
                {2'b11, k == 3, 16'h0010 + 16'(k), 16'h0020 + 16'(k)}) begin
                n_fail++;
                $display("FAIL basic_pair%0d: got v=%b%b d=%b a=%h b=%h expected v=11 d=%b a=%h b=%h", k, bus.mac_valid_a,
                         bus.mac_valid_b, bus.vec_done, bus.mac_a, bus.mac_b, k == 3, 16'h0010 + 16'(k), 16'h0020 + 16'(k));
            end
        end
        tick();
        n_checks++;
        if ({bus.mac_valid_a, bus.vec_done, bus.busy} !== 3'b000) begin n_fail++; $display("FAIL basic_end: got %b expected 000", {bus.mac_valid_a, bus.vec_done, bus.busy}); end
    endtask

    task automatic test_skew();
        int pairs = 0;
        for (int c = 0; c < 5; c++) begin
            bus.cfg_req = c == 0; bus.cfg_len = 8'd3; bus.cfg_float_int = 1'b1;
            bus.a_valid = c < 3; bus.a_data = 16'(c + 1);
            tick();
            n_checks++;
            if (bus.mac_valid_a !== 1'b0 || bus.mac_valid_b !== 1'b0) begin n_fail++; $display("FAIL skew_no_b_valid: got %b%b expected 00", bus.mac_valid_a, bus.mac_valid_b); end
        end
        bus.cfg_req = 0; bus.a_valid = 0;
        for (int c = 0; c < 12; c++) begin
            bus.b_valid = c < 3; bus.b_data = 16'hB001 + 16'(c);
            tick();
            n_checks++;
            if (bus.mac_valid_a !== bus.mac_valid_b) begin n_fail++; $display("FAIL skew_valid_eq: got %b%b expected equal", bus.mac_valid_a, bus.mac_valid_b); end
            if (bus.mac_valid_a === 1'b1) begin
                n_checks++;
                if ({bus.mac_a, bus.mac_b, bus.vec_done} !== {16'(pairs + 1), 16'hB001 + 16'(pairs), pairs == 2}) begin
                    n_fail++;
                    $display("FAIL skew_pair%0d: got a=%h b=%h d=%b expected a=%h b=%h d=%b", pairs, bus.mac_a, bus.mac_b, bus.vec_done,
                             16'(pairs + 1), 16'hB001 + 16'(pairs), pairs == 2);
                end
                pairs++;
            end
        end
        bus.b_valid = 0;
        n_checks++;
        if (pairs != 3) begin n_fail++; $display("FAIL skew_count: got %0d expected 3", pairs); end
        n_checks++;
        if (bus.float_int !== 1'b1) begin n_fail++; $display("FAIL skew_float: got %b expected 1", bus.float_int); end
    endtask

    task automatic test_full();
        int pairs = 0;
        for (int i = 0; i < 8; i++) begin
            bus.a_valid = 1; bus.a_data = 16'h00A0 + 16'(i);
            tick();
        end
        n_checks++;
        if (bus.a_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", bus.a_ready); end
        bus.a_data = 16'h00FF;
        tick();
        bus.a_valid = 0;
        n_checks++;
        if (bus.a_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_held: got %b expected 0", bus.a_ready); end
        bus.cfg_req = 1; bus.cfg_len = 8'd8; bus.cfg_float_int = 0;
        tick();
        bus.cfg_req = 0;
        for (int c = 0; c < 24; c++) begin
            bus.b_valid = c < 8; bus.b_data = 16'h00C0 + 16'(c);
            tick();
            if (bus.mac_valid_a === 1'b1) begin
                n_checks++;
                if ({bus.mac_a, bus.mac_b, bus.vec_done} !== {16'h00A0 + 16'(pairs), 16'h00C0 + 16'(pairs), pairs == 7}) begin
                    n_fail++;
                    $display("FAIL full_pair%0d: got a=%h b=%h d=%b", pairs, bus.mac_a, bus.mac_b, bus.vec_done);
                end
                pairs++;
            end
        end
        bus.b_valid = 0;
        n_checks++;
        if (pairs != 8) begin n_fail++; $display("FAIL full_count: got %0d expected 8", pairs); end
        n_checks++;
        if (bus.a_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_back: got %b expected 1", bus.a_ready); end
        pairs = 0;
        for (int c = 0; c < 10; c++) begin
            bus.a_valid = c == 0; bus.a_data = 16'h0055;
            bus.b_valid = c == 0; bus.b_data = 16'h0066;
            bus.cfg_req = c == 0; bus.cfg_len = 8'd1;
            tick();
            if (bus.mac_valid_a === 1'b1) begin
                n_checks++;
                if ({bus.mac_a, bus.mac_b, bus.vec_done} !== {16'h0055, 16'h0066, 1'b1}) begin
                    n_fail++;
                    $display("FAIL full_refused_word: got a=%h b=%h d=%b expected a=0055 b=0066 d=1", bus.mac_a, bus.mac_b, bus.vec_done);
                end
                pairs++;
            end
        end
        bus.a_valid = 0; bus.b_valid = 0; bus.cfg_req = 0;
        n_checks++;
        if (pairs != 1) begin n_fail++; $display("FAIL full_single_count: got %0d expected 1", pairs); end
    endtask

    task automatic test_len256();
        int a_sent = 0, b_sent = 0, pairs = 0, cyc = 0;
        logic a_acc, b_acc;
        bus.cfg_req = 1; bus.cfg_len = 8'd0; bus.cfg_float_int = 0;
        tick();
        bus.cfg_req = 0;
        n_checks++;
        if ({bus.cfg_ack, bus.data_num} !== 9'h100) begin n_fail++; $display("FAIL len256_cfg: got %h expected 100", {bus.cfg_ack, bus.data_num}); end
        while (pairs < 256 && cyc < 1000) begin
            bus.a_valid = a_sent < 256; bus.a_data = 16'h1000 + 16'(a_sent);
            bus.b_valid = b_sent < 256; bus.b_data = 16'h2000 + 16'(b_sent);
            if (pairs >= 100) begin bus.cfg_req = 1; bus.cfg_len = 8'd2; bus.cfg_float_int = 1; end
            a_acc = bus.a_valid && bus.a_ready;
            b_acc = bus.b_valid && bus.b_ready;
            tick();
            cyc++;
            if (a_acc) a_sent++;
            if (b_acc) b_sent++;
            n_checks++;
            if (bus.cfg_ack !== 1'b0 || bus.mac_valid_a !== bus.mac_valid_b) begin
                n_fail++;
                $display("FAIL len256_ack_or_valid: got ack=%b v=%b%b expected ack=0 equal valids", bus.cfg_ack, bus.mac_valid_a, bus.mac_valid_b);
            end
            if (bus.mac_valid_a === 1'b1) begin
                n_checks++;
                if ({bus.mac_a, bus.mac_b, bus.vec_done} !== {16'h1000 + 16'(pairs), 16'h2000 + 16'(pairs), pairs == 255}) begin
                    n_fail++;
                    $display("FAIL len256_pair%0d: got a=%h b=%h d=%b", pairs, bus.mac_a, bus.mac_b, bus.vec_done);
                end
                pairs++;
            end
        end
        bus.a_valid = 0; bus.b_valid = 0;
        n_checks++;
        if (pairs != 256) begin n_fail++; $display("FAIL len256_count: got %0d expected 256", pairs); end
        n_checks++;
        if ({bus.busy, bus.float_int, bus.data_num} !== 10'h000) begin n_fail++; $display("FAIL len256_idle: got %h expected 000", {bus.busy, bus.float_int, bus.data_num}); end
        tick();
        bus.cfg_req = 0;
        n_checks++;
        if ({bus.cfg_ack, bus.float_int, bus.data_num} !== 10'h302) begin n_fail++; $display("FAIL len256_late_ack: got %h expected 302", {bus.cfg_ack, bus.float_int, bus.data_num}); end
        pairs = 0;
        for (int c = 0; c < 10; c++) begin
            bus.a_valid = c < 2; bus.a_data = 16'h3000 + 16'(c);
            bus.b_valid = c < 2; bus.b_data = 16'h4000 + 16'(c);
            tick();
            if (bus.mac_valid_a === 1'b1) begin
                n_checks++;
                if ({bus.mac_a, bus.mac_b, bus.vec_done} !== {16'h3000 + 16'(pairs), 16'h4000 + 16'(pairs), pairs == 1}) begin
                    n_fail++;
                    $display("FAIL len256_next_pair%0d: got a=%h b=%h d=%b", pairs, bus.mac_a, bus.mac_b, bus.vec_done);
                end
                pairs++;
            end
        end
        bus.a_valid = 0; bus.b_valid = 0;
        n_checks++;
        if (pairs != 2) begin n_fail++; $display("FAIL len256_next_count: got %0d expected 2", pairs); end
    endtask

    task automatic test_reset_mid();
        int pairs = 0, cyc = 0;
        for (int i = 0; i < 5; i++) push_pair(16'h0E10 + 16'(i), 16'h0E20 + 16'(i));
        bus.cfg_req = 1; bus.cfg_len = 8'd5;
        tick();
        bus.cfg_req = 0;
        while (pairs < 2 && cyc < 20) begin
            tick();
            cyc++;
            if (bus.mac_valid_a === 1'b1) pairs++;
        end
        n_checks++;
        if (pairs != 2) begin n_fail++; $display("FAIL mid_two_pairs: got %0d expected 2", pairs); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.cfg_ack, bus.config_en, bus.float_int, bus.data_num, bus.mac_a, bus.mac_b, bus.mac_valid_a,
             bus.mac_valid_b, bus.busy, bus.vec_done, bus.a_ready, bus.b_ready} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got a=%h v=%b busy=%b ready=%b%b expected all 0", bus.mac_a, bus.mac_valid_a, bus.busy, bus.a_ready, bus.b_ready);
        end
        #1 rst_n = 1'b1;
        tick();
        n_checks++;
        if ({bus.a_ready, bus.b_ready, bus.busy} !== 3'b110) begin n_fail++; $display("FAIL mid_release: got %b expected 110", {bus.a_ready, bus.b_ready, bus.busy}); end
        pairs = 0;
        for (int c = 0; c < 10; c++) begin
            bus.a_valid = c == 0; bus.a_data = 16'h0077;
            bus.b_valid = c == 0; bus.b_data = 16'h0088;
            bus.cfg_req = c == 0; bus.cfg_len = 8'd1;
            tick();
            if (bus.mac_valid_a === 1'b1) begin
                n_checks++;
                if ({bus.mac_a, bus.mac_b, bus.vec_done} !== {16'h0077, 16'h0088, 1'b1}) begin
                    n_fail++;
                    $display("FAIL mid_after_pair: got a=%h b=%h d=%b expected a=0077 b=0088 d=1", bus.mac_a, bus.mac_b, bus.vec_done);
                end
                pairs++;
            end
        end
        bus.a_valid = 0; bus.b_valid = 0; bus.cfg_req = 0;
        n_checks++;
        if (pairs != 1) begin n_fail++; $display("FAIL mid_after_count: got %0d expected 1", pairs); end
    endtask

`ifdef MAC_FEEDER_STALL_CNT_EN
    task automatic test_stall_cnt();
        logic done = 1'b0;
        bus.a_valid = 1; bus.a_data = 16'h0005;
        tick();
        bus.a_valid = 0;
        bus.cfg_req = 1; bus.cfg_len = 8'd2;
        tick();
        bus.cfg_req = 0;
        n_checks++;
        if (bus.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL stall_start: got %0d expected 0", bus.stall_cnt); end
        repeat (12) tick();
        n_checks++;
        if (bus.stall_cnt !== 16'd10) begin n_fail++; $display("FAIL stall_count: got %0d expected 10", bus.stall_cnt); end
        for (int c = 0; c < 20 && !done; c++) begin
            bus.b_valid = c < 2; bus.b_data = 16'h0009;
            bus.a_valid = c == 1; bus.a_data = 16'h0006;
            tick();
            done = bus.vec_done;
        end
        bus.a_valid = 0; bus.b_valid = 0;
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL stall_vec_done: got %b expected 1", done); end
        bus.cfg_req = 1; bus.cfg_len = 8'd1;
        tick();
        bus.cfg_req = 0;
        n_checks++;
        if ({bus.cfg_ack, bus.stall_cnt} !== {1'b1, 16'd0}) begin n_fail++; $display("FAIL stall_clear: got ack=%b cnt=%0d expected ack=1 cnt=0", bus.cfg_ack, bus.stall_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_skew();
        test_full();
        test_len256();
        test_reset_mid();
`ifdef MAC_FEEDER_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
